ps2_scan_ctrl: RTL
==================

# ps2_scan_ctrl

Scan-code sequencer that sits between the PS/2 frame receiver and the keyboard consumers. It takes the receiver's one-cycle byte strobe, strips the 0xE0 (extended) and 0xF0 (break) prefixes, and assembles complete key events of the form {extended, break, code}. Events are buffered in a small FIFO with a valid/ready handshake. Frames the receiver zeroed for parity or stop-bit failure, and non-key bytes, are counted and dropped.

## Interface
- DEPTH, 8: event FIFO depth; must be a power of 2, at least 2.
- TIMEOUT_CYC, 50000: clock cycles a prefix may wait for its next byte. Used only with PS2_SCAN_TIMEOUT_EN.
- clk  in  1  system clock; one clock domain. Reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: the receiver has completed a frame.
- rx_data  in  8  received byte; sampled only when rx_valid=1.
- evt_valid  out  1  FIFO not empty.
- evt_ext  out  1  head event was E0-prefixed.
- evt_break  out  1  head event is a key release.
- evt_code  out  8  head event scan code.
- evt_ready  in  1  consumer pops the head when evt_valid & evt_ready.
- ovf  out  1  sticky flag: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf; a new drop in the same cycle wins.
- err_cnt  out  8  saturating count of bad or aborted bytes.

## Operation
- State machine: S_IDLE, S_E0, S_F0, S_E0F0. All transitions happen only on rx_valid, except the timeout.
- In S_IDLE:
  - 0xE0 → S_E0.
  - 0xF0 → S_F0.
- In S_E0:
  - 0xF0 → S_E0F0.
  - 0xE0 → stay in S_E0.
- Any other byte in S_IDLE, S_E0, S_F0 or S_E0F0:
  - Byte is a key code → push {ext, brk, byte} and return to S_IDLE.
  - ext=1 in S_E0 and S_E0F0.
  - brk=1 in S_F0 and S_E0F0.
- Key code: any byte except 0x00, 0xE0, 0xF0, 0xE1, 0xAA, 0xEE, 0xFA, 0xFE.
- 0xF0 received in S_F0 or S_E0F0 → err_cnt+1, go to S_IDLE.
- 0xE0 received in S_F0 or S_E0F0 → err_cnt+1, go to S_E0.
- 0x00 (zeroed bad frame) in any state → err_cnt+1, go to S_IDLE, no push.
- 0xE1, 0xAA, 0xEE, 0xFA, 0xFE → no push, no count, go to S_IDLE.
- Push while full (and no pop in the same cycle) → event dropped, ovf set. State still returns to S_IDLE.
- Push and pop in the same cycle, including when full → both take effect; occupancy is unchanged.
- err_cnt saturates at 0xFF.
- Reset mid-sequence → S_IDLE, FIFO emptied, partial prefix discarded.

## Timing
- Reset values:
  - evt_valid=0, evt_ext=0, evt_break=0, evt_code=0x00.
  - ovf=0, err_cnt=0x00.
  - State S_IDLE, FIFO pointers 0.
- Latency: rx_valid with a completing key byte at edge N → evt_valid=1 after edge N.
- FIFO is show-ahead: evt_* reflect the head combinationally from the registered array and pointers.
- Pop at edge N → next entry, or evt_valid=0, after edge N.
- Consecutive rx_valid strobes on adjacent cycles must be accepted without loss.
- evt_* must be held stable while evt_valid=1 and evt_ready=0.

## Configuration
- PS2_SCAN_TIMEOUT_EN defined:
  - A counter clears on every rx_valid and runs while the state is not S_IDLE.
  - When it reaches TIMEOUT_CYC-1 without rx_valid → S_IDLE, err_cnt+1, no push.
  - rx_valid on the expiry cycle takes priority: the byte is processed normally.
- PS2_SCAN_TIMEOUT_EN undefined: no counter is built, and prefix states are held indefinitely.

## Structure
- Shared package ps2_pkg:
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, and the ignored-byte codes.
  - State enum for the four states.
  - Event struct {ext, brk, code[7:0]}, 10 bits.
- Sub-module ps2_evt_fifo holds the DEPTH×10 array, the pointers and full/empty logic, plus a push/pop port.
- The sequencer FSM, err_cnt, ovf and the timeout counter live in the top module.

## Test plan
- Bytes 0x1C → one event ext=0, brk=0, code=0x1C, evt_valid one cycle after the strobe. Bytes F0,1C → brk=1, code=0x1C.
- Bytes E0,F0,75 with evt_ready=0 → event ext=1, brk=1, code=0x75, held stable until ready is raised.
- With evt_ready=0, push DEPTH+1 key codes → first DEPTH events retained in order, ovf=1. ovf_clr → ovf=0. Push and pop while full → count stays DEPTH.
- Bytes 0x00, then F0,F0, then E0,FA → err_cnt=2, no events, state S_IDLE.
- With the macro defined and TIMEOUT_CYC=16: E0, then idle 16 cycles, then 0x1C → err_cnt=1, event ext=0. With the macro undefined → event ext=1.
- Assert rst_n low after the F0 byte, release, then send 0x1C → event brk=0, err_cnt=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM state type and key-event record for the PS/2 scan sequencer.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAD    = 8'h00;
    localparam logic [7:0] PS2_E1     = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    // Keyboard status/response bytes that are neither key codes nor errors.
    function automatic logic is_ignored(input logic [7:0] b);
        return b inside {PS2_E1, PS2_BAT, PS2_ECHO, PS2_ACK, PS2_RESEND};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: show-ahead DEPTH x 10-bit event FIFO with simultaneous push/pop.
// Ports: clk, rst_n (async active-low); push_i/din_i write; pop_i read;
//        dout_o head entry (zero while empty); empty_o, full_o status.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  evt_t din_i,
    input  logic pop_i,
    output evt_t dout_o,
    output logic empty_o,
    output logic full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, rd_q;
    evt_t        mem_q [DEPTH];
    logic        do_pop, do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: strips E0/F0 prefixes from PS/2 bytes and queues {ext, break, code} key events.
// Ports: clk, rst_n (async active-low); rx_valid/rx_data receiver strobe and byte;
//        evt_valid/evt_ext/evt_break/evt_code head event, popped by evt_ready;
//        ovf sticky drop flag cleared by ovf_clr; err_cnt saturating error count.
// Option: define PS2_SCAN_TIMEOUT_EN to abandon a prefix after TIMEOUT_CYC idle cycles.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       evt_valid,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] evt_code,
    input  logic       evt_ready,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic [7:0] err_cnt
);

    state_t     state_q, state_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       ovf_q, ovf_d;
    logic       push, err, tmo, full, empty, ext_pend, brk_pend;
    evt_t       head;

    assign ext_pend = state_q inside {S_E0, S_E0F0};
    assign brk_pend = state_q inside {S_F0, S_E0F0};

`ifdef PS2_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    assign tmo    = (state_q != S_IDLE) && (tcnt_q == TW'(TIMEOUT_CYC - 1));
    assign tcnt_d = (rx_valid || state_q == S_IDLE) ? '0 : tcnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt_q <= '0;
        else        tcnt_q <= tcnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        err     = 1'b0;
        if (rx_valid) begin
            if (rx_data == PS2_BAD) begin
                err     = 1'b1;
                state_d = S_IDLE;
            end else if (rx_data == PS2_EXT) begin
                // A second E0 is harmless; E0 after a pending F0 aborts the break.
                err     = brk_pend;
                state_d = S_E0;
            end else if (rx_data == PS2_BRK) begin
                err     = brk_pend;
                state_d = brk_pend ? S_IDLE : ext_pend ? S_E0F0 : S_F0;
            end else begin
                push    = !is_ignored(rx_data);
                state_d = S_IDLE;
            end
        end else if (tmo) begin
            err     = 1'b1;
            state_d = S_IDLE;
        end
    end

    // Full FIFO implies non-empty, so a raised evt_ready always frees a slot.
    assign err_cnt_d = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    assign ovf_d     = (push && full && !evt_ready) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ('{ext: ext_pend, brk: brk_pend, code: rx_data}),
        .pop_i   (evt_ready),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

    assign evt_valid = !empty;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
    assign evt_code  = head.code;
    assign ovf       = ovf_q;
    assign err_cnt   = err_cnt_q;

endmodule
